// File: rtl/minpool_pkg.sv
// Shared constants and types for the min-pool datapath and its stream transmitter.
package minpool_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned IN_DIM      = 8;
  localparam int unsigned WIN         = 3;
  localparam int unsigned OUT_DIM     = IN_DIM - WIN + 1;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } tx_state_e;

endpackage

// File: rtl/minpool_stream_tx_if.sv
// Valid/ready element stream carrying one pooled element plus its raster position per beat.
interface minpool_stream_tx_if #(
  parameter int unsigned DATA_WIDTH = minpool_pkg::DATA_WIDTH,
  parameter int unsigned ROWS       = minpool_pkg::OUT_DIM,
  parameter int unsigned COLS       = minpool_pkg::OUT_DIM
);

  logic                    m_valid;
  logic                    m_ready;
  logic [DATA_WIDTH-1:0]   m_data;
  logic [$clog2(ROWS)-1:0] m_row;
  logic [$clog2(COLS)-1:0] m_col;
  logic                    m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_row,
    output m_col,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_row,
    input  m_col,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/minpool_rc_counter.sv
// Row/column raster counter: col advances on en, wraps into row; last flags the final element.
module minpool_rc_counter #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic                    last,
  output logic                    wrap
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             col_end;
  logic             row_end;

  assign col_end = (col_q == COL_W'(COLS - 1));
  assign row_end = (row_q == ROW_W'(ROWS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = row_end && col_end;
  assign wrap = en && last;

endmodule

// File: rtl/minpool_stream_tx.sv
// Snapshots a pooled map in one cycle and streams it out in raster order over valid/ready.
// Optional per-frame minimum output enabled by defining MINPOOL_TX_FRAME_MIN_EN.
module minpool_stream_tx #(
  parameter int unsigned DATA_WIDTH = minpool_pkg::DATA_WIDTH,
  parameter int unsigned ROWS       = minpool_pkg::OUT_DIM,
  parameter int unsigned COLS       = minpool_pkg::OUT_DIM
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                map_valid,
  output logic                                map_ready,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0]     pooled_flat,
  minpool_stream_tx_if.master                 m,
  output logic                                frame_done,
  output logic [minpool_pkg::FRAME_CNT_W-1:0] frame_cnt
`ifdef MINPOOL_TX_FRAME_MIN_EN
  ,
  output logic [DATA_WIDTH-1:0]               frame_min,
  output logic                                frame_min_valid
`endif
);

  import minpool_pkg::*;

  localparam int unsigned NUM   = ROWS * COLS;
  localparam int unsigned IDX_W = $clog2(NUM);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  tx_state_e                 state_q, state_d;
  logic [NUM*DATA_WIDTH-1:0] snap_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      ready_q;
  logic                      done_q;
  logic [FRAME_CNT_W-1:0]    cnt_q;

  logic                      capture;
  logic                      sending;
  logic                      xfer;
  logic [ROW_W-1:0]          row;
  logic [COL_W-1:0]          col;
  logic                      rc_last;
  logic                      rc_wrap;
  logic [DATA_WIDTH-1:0]     cur_data;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ready_q && map_valid) begin
          capture = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (rc_wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sending  = (state_q == StSend);
  assign xfer     = sending && m.m_ready;
  assign cur_data = snap_q[idx_q*DATA_WIDTH +: DATA_WIDTH];

  minpool_rc_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_rc (
    .clk  (clk),
    .rst  (rst),
    .clr  (capture),
    .en   (xfer),
    .row  (row),
    .col  (col),
    .last (rc_last),
    .wrap (rc_wrap)
  );

  // map_ready is registered so it stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle);
      done_q  <= rc_wrap;
      cnt_q   <= cnt_q + FRAME_CNT_W'(rc_wrap);
      if (capture) begin
        snap_q <= pooled_flat;
        idx_q  <= '0;
      end else if (xfer) begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  assign map_ready  = ready_q;
  assign m.m_valid  = sending;
  assign m.m_data   = sending ? cur_data : '0;
  assign m.m_row    = row;
  assign m.m_col    = col;
  assign m.m_last   = sending && rc_last;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;

`ifdef MINPOOL_TX_FRAME_MIN_EN
  logic [DATA_WIDTH-1:0] run_min_q;
  logic [DATA_WIDTH-1:0] beat_min;
  logic [DATA_WIDTH-1:0] fmin_q;
  logic                  fmin_valid_q;

  // Include the beat being transferred so the last element counts toward the published minimum.
  assign beat_min = (cur_data < run_min_q) ? cur_data : run_min_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_min_q    <= '1;
      fmin_q       <= '0;
      fmin_valid_q <= 1'b0;
    end else begin
      fmin_valid_q <= rc_wrap;
      if (capture) begin
        run_min_q <= '1;
      end else if (xfer) begin
        run_min_q <= beat_min;
      end
      if (rc_wrap) begin
        fmin_q <= beat_min;
      end
    end
  end

  assign frame_min       = fmin_q;
  assign frame_min_valid = fmin_valid_q;
`endif

endmodule
